// File: rtl/data_mem_pkg.sv
// data_mem_pkg: FSM/op types and MMIO constants shared by data_mem_ctrl and mmio_regs
package data_mem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, ACCESS} state_t;
  typedef enum logic {OP_RD, OP_WR} op_t;
  localparam logic [3:0] MMIO_GPIO_OUT = 4'd0;
  localparam logic [3:0] MMIO_GPIO_IN = 4'd1;
  localparam int MMIO_SIZE = 16;
endpackage

// File: rtl/mmio_regs.sv
// mmio_regs: gpio_out register, 2-flop gpio_in synchroniser and offset readback for the MMIO window
import data_mem_pkg::*;

module mmio_regs #(
  parameter int DATA_W = 16,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [3:0]        offset,
  input  logic [GPIO_W-1:0] wdata,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out,
  output logic [DATA_W-1:0] rdata
);
  logic [GPIO_W-1:0] sync1, sync2;
  always_ff @(posedge clk) begin
    if (!reset) begin
      gpio_out <= '0;
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= gpio_in;
      sync2 <= sync1;
      if (wr_en && offset == MMIO_GPIO_OUT) gpio_out <= wdata;
    end
  end
  always_comb rdata = offset == MMIO_GPIO_OUT ? DATA_W'(gpio_out) :
                      offset == MMIO_GPIO_IN  ? DATA_W'(sync2) : '0;
endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: wait-stated data RAM controller with GPIO MMIO window; MEM_BOUNDS_CHECK_EN adds mem_fault
import data_mem_pkg::*;

module data_mem_ctrl #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 16,
  parameter int DEPTH = 2048,
  parameter int WAIT_STATES = 1,
  parameter int MMIO_BASE = 'hFF0,
  parameter int GPIO_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_rd,
  input  logic              mem_wr,
  input  logic [ADDR_W-1:0] ram_addr,
  input  logic [DATA_W-1:0] data_mem_in,
  output logic [DATA_W-1:0] data_mem_out,
  output logic              mem_ready,
  output logic              mem_busy,
  input  logic [GPIO_W-1:0] gpio_in,
  output logic [GPIO_W-1:0] gpio_out
`ifdef MEM_BOUNDS_CHECK_EN
  ,
  output logic              mem_fault
`endif
);
  localparam int RAM_AW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  state_t state, state_nx;
  op_t op;
  logic [3:0] cnt;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata, mmio_rdata, rd_val;
  logic in_ram, in_mmio, commit;
  logic [DATA_W-1:0] ram [DEPTH];
  always_comb begin
    in_ram = 32'(addr) < DEPTH;
    in_mmio = 32'(addr) >= MMIO_BASE && 32'(addr) < MMIO_BASE + MMIO_SIZE;
    commit = state == ACCESS;
    rd_val = in_ram ? ram[addr[RAM_AW-1:0]] : in_mmio ? mmio_rdata : '0;
  end
  always_comb begin
    state_nx = state;
    mem_ready = state == ACCESS;
    mem_busy = state != IDLE;
    case (state)
      IDLE:    if (mem_rd || mem_wr) state_nx = WAIT_STATES > 0 ? WAIT : ACCESS;
      WAIT:    if (cnt == '0) state_nx = ACCESS;
      default: state_nx = IDLE;
    endcase
  end
`ifdef MEM_BOUNDS_CHECK_EN
  always_comb mem_fault = commit && !in_ram && !in_mmio;
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      data_mem_out <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && (mem_rd || mem_wr)) begin
        addr <= ram_addr;
        wdata <= data_mem_in;
        op <= mem_wr ? OP_WR : OP_RD;
        cnt <= WAIT_STATES > 0 ? 4'(WAIT_STATES - 1) : '0;
      end else if (state == WAIT) begin
        cnt <= cnt - 1'b1;
      end
      if (commit && op == OP_RD) data_mem_out <= rd_val;
    end
  end
  always_ff @(posedge clk) begin
    if (reset && commit && op == OP_WR && in_ram) ram[addr[RAM_AW-1:0]] <= wdata;
  end
  mmio_regs #(.DATA_W(DATA_W), .GPIO_W(GPIO_W)) u_mmio (
    .clk(clk),
    .reset(reset),
    .wr_en(commit && op == OP_WR && in_mmio),
    .offset(4'(32'(addr) - MMIO_BASE)),
    .wdata(wdata[GPIO_W-1:0]),
    .gpio_in(gpio_in),
    .gpio_out(gpio_out),
    .rdata(mmio_rdata)
  );
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: three controllers (0/1/3 wait states) checked against a behavioural memory map model
module tb_data_mem_ctrl;
  localparam int N = 3;
  localparam int DEPTH = 2048;
  localparam int MMIO = 'hFF0;
  logic clk = 1'b0;
  logic rst_n [N];
  logic rd [N];
  logic wr [N];
  logic [11:0] addr [N];
  logic [15:0] din [N];
  logic [15:0] dout [N];
  logic rdy [N];
  logic busy [N];
  logic [7:0] gin [N];
  logic [7:0] gout [N];
`ifdef MEM_BOUNDS_CHECK_EN
  logic fault [N];
`endif
  int n_vec = 0;
  int n_err = 0;
  int ws_of [N] = '{0, 1, 3};
  logic [15:0] m_ram [N][DEPTH];
  bit m_vld [N][DEPTH];
  logic [15:0] m_dout [N];
  logic [7:0] m_gout [N];
  logic [7:0] m_gin [N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    localparam int W = g == 0 ? 0 : g == 1 ? 1 : 3;
    data_mem_ctrl #(.WAIT_STATES(W)) dut (
      .clk(clk),
      .reset(rst_n[g]),
      .mem_rd(rd[g]),
      .mem_wr(wr[g]),
      .ram_addr(addr[g]),
      .data_mem_in(din[g]),
      .data_mem_out(dout[g]),
      .mem_ready(rdy[g]),
      .mem_busy(busy[g]),
      .gpio_in(gin[g]),
      .gpio_out(gout[g])
`ifdef MEM_BOUNDS_CHECK_EN
      ,
      .mem_fault(fault[g])
`endif
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] m_read(input int d, input int a);
    if (a < DEPTH) return m_ram[d][a];
    if (a == MMIO) return {8'h00, m_gout[d]};
    if (a == MMIO + 1) return {8'h00, m_gin[d]};
    return 16'h0000;
  endfunction

  task automatic set_gpio_in(input int d, input logic [7:0] v);
    @(negedge clk);
    gin[d] = v;
    m_gin[d] = v;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic access(input int d, input bit r, input bit w, input logic [11:0] a, input logic [15:0] v);
    int lat;
    int ia;
    bit hole;
    ia = int'(a);
    hole = ia >= DEPTH && ia < MMIO;
    @(negedge clk);
    rd[d] = r;
    wr[d] = w;
    addr[d] = a;
    din[d] = v;
    @(posedge clk);
    #1;
    check($sformatf("busy_start%0d", d), 32'(busy[d]), 1);
    lat = 1;
    while (!rdy[d] && lat < 20) begin
      rd[d] = 1'($urandom);
      wr[d] = 1'($urandom);
      addr[d] = 12'($urandom);
      din[d] = 16'($urandom);
      @(posedge clk);
      #1;
      lat++;
    end
    rd[d] = 1'b0;
    wr[d] = 1'b0;
    check($sformatf("latency%0d", d), 32'(lat), 32'(ws_of[d] + 1));
`ifdef MEM_BOUNDS_CHECK_EN
    check($sformatf("fault%0d@%0h", d, a), 32'(fault[d]), 32'(hole));
`endif
    if (w) begin
      if (ia < DEPTH) begin
        m_ram[d][ia] = v;
        m_vld[d][ia] = 1'b1;
      end else if (ia == MMIO) begin
        m_gout[d] = v[7:0];
      end
    end else if (r) begin
      m_dout[d] = m_read(d, ia);
    end
    @(posedge clk);
    #1;
    check($sformatf("ready_clr%0d", d), 32'(rdy[d]), 0);
    check($sformatf("busy_clr%0d", d), 32'(busy[d]), 0);
    check($sformatf("dout%0d@%0h", d, a), 32'(dout[d]), 32'(m_dout[d]));
    check($sformatf("gpio_out%0d", d), 32'(gout[d]), 32'(m_gout[d]));
`ifdef MEM_BOUNDS_CHECK_EN
    check($sformatf("fault_clr%0d", d), 32'(fault[d]), 0);
`endif
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rst_n[i] = 1'b0;
      rd[i] = 1'b0;
      wr[i] = 1'b0;
      addr[i] = '0;
      din[i] = '0;
      gin[i] = '0;
      m_dout[i] = '0;
      m_gout[i] = '0;
      m_gin[i] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_dout%0d", i), 32'(dout[i]), 0);
      check($sformatf("rst_ready%0d", i), 32'(rdy[i]), 0);
      check($sformatf("rst_busy%0d", i), 32'(busy[i]), 0);
      check($sformatf("rst_gpio%0d", i), 32'(gout[i]), 0);
    end
    @(negedge clk);
    for (int i = 0; i < N; i++) rst_n[i] = 1'b1;
    access(1, 0, 1, 12'h010, 16'h1234);
    access(1, 1, 0, 12'h010, 16'h0000);
    check("t1_dout", 32'(dout[1]), 32'h1234);
    access(0, 0, 1, 12'h000, 16'h1111);
    access(0, 0, 1, 12'h001, 16'h2222);
    access(0, 1, 0, 12'h000, 16'h0000);
    access(0, 1, 0, 12'h001, 16'h0000);
    check("t2_dout", 32'(dout[0]), 32'h2222);
    access(1, 0, 1, 12'(MMIO), 16'h00A5);
    check("t3_gpio_out", 32'(gout[1]), 32'hA5);
    access(1, 1, 0, 12'(MMIO), 16'h0000);
    check("t3_gpio_rd", 32'(dout[1]), 32'h00A5);
    set_gpio_in(1, 8'h3C);
    access(1, 1, 0, 12'(MMIO + 1), 16'h0000);
    check("t3_gpio_in", 32'(dout[1]), 32'h003C);
    access(1, 1, 1, 12'h020, 16'hBEEF);
    check("t4_dout_held", 32'(dout[1]), 32'h003C);
    access(1, 1, 0, 12'h020, 16'h0000);
    check("t4_ram", 32'(dout[1]), 32'hBEEF);
    access(1, 0, 1, 12'(DEPTH), 16'hDEAD);
    access(1, 1, 0, 12'(DEPTH), 16'h0000);
    check("hole_rd", 32'(dout[1]), 0);
    access(1, 0, 1, 12'(MMIO + 5), 16'h00FF);
    access(1, 1, 0, 12'(MMIO + 5), 16'h0000);
    check("mmio_gap_rd", 32'(dout[1]), 0);
    access(2, 0, 1, 12'h030, 16'h1111);
    access(2, 0, 1, 12'(MMIO), 16'h005A);
    access(2, 1, 0, 12'h030, 16'h0000);
    @(negedge clk);
    wr[2] = 1'b1;
    addr[2] = 12'h030;
    din[2] = 16'hFFFF;
    @(posedge clk);
    #1;
    wr[2] = 1'b0;
    check("t5_busy", 32'(busy[2]), 1);
    @(negedge clk);
    rst_n[2] = 1'b0;
    @(posedge clk);
    #1;
    m_dout[2] = '0;
    m_gout[2] = '0;
    check("t5_dout", 32'(dout[2]), 0);
    check("t5_ready", 32'(rdy[2]), 0);
    check("t5_busy_rst", 32'(busy[2]), 0);
    check("t5_gpio", 32'(gout[2]), 0);
`ifdef MEM_BOUNDS_CHECK_EN
    check("t5_fault", 32'(fault[2]), 0);
`endif
    @(negedge clk);
    rst_n[2] = 1'b1;
    access(2, 1, 0, 12'h030, 16'h0000);
    check("t5_ram_kept", 32'(dout[2]), 32'h1111);
    for (int d = 0; d < N; d++) begin
      for (int it = 0; it < 60; it++) begin
        int k;
        int op;
        logic [11:0] a;
        k = $urandom_range(0, 9);
        op = $urandom_range(0, 2);
        a = k < 5 ? 12'($urandom_range(0, 63)) :
            k < 7 ? 12'($urandom_range(DEPTH, MMIO - 1)) : 12'(MMIO + $urandom_range(0, 15));
        if (op == 0 && int'(a) < DEPTH && !m_vld[d][int'(a)]) op = 1;
        if ($urandom_range(0, 7) == 0) set_gpio_in(d, 8'($urandom));
        access(d, op != 1, op != 0, a, 16'($urandom));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
